// File: rtl/axi2mem_tcdm_rw_arb.sv
// Shares one TCDM port between the read and write request streams and routes in-order responses back with their IDs.
// Latency: zero added cycles on both the request and response paths, which are purely combinational.
// Backpressure: a stalled request locks the grant until it is taken; no new request is issued while the tracker is full.
module axi2mem_tcdm_rw_arb #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [1:0]                       ch_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]       ch_add_i,
    input  logic [1:0]                       ch_we_i,
    input  logic [1:0][DATA_WIDTH-1:0]       ch_wdata_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]     ch_be_i,
    input  logic [1:0][ID_WIDTH-1:0]         ch_id_i,
    output logic [1:0]                       ch_gnt_o,
    output logic [1:0]                       ch_r_valid_o,
    output logic [DATA_WIDTH-1:0]            ch_r_rdata_o,
    output logic [ID_WIDTH-1:0]              ch_r_id_o,
    output logic                             tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]            tcdm_add_o,
    output logic                             tcdm_we_o,
    output logic [DATA_WIDTH-1:0]            tcdm_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          tcdm_be_o,
    input  logic                             tcdm_gnt_i,
    input  logic                             tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            tcdm_r_rdata_i,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                owner;
        logic [ID_WIDTH-1:0] id;
    } trk_entry_t;

    trk_entry_t       trk_q [MAX_OUTSTANDING];
    trk_entry_t       head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_q, lock_q, locked_ch_q, err_q;
    logic             full, empty, push, pop, winner;
    logic [1:0]       eligible;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty    = (cnt_q == '0);
    assign eligible = full ? 2'b00 : ch_req_i;

    always_comb begin
        winner = rr_q;
        if (lock_q)
            winner = locked_ch_q;
        else if (eligible == 2'b01)
            winner = 1'b0;
        else if (eligible == 2'b10)
            winner = 1'b1;
    end

    assign tcdm_req_o   = lock_q | (|eligible);
    assign push         = tcdm_req_o & tcdm_gnt_i;
    assign tcdm_add_o   = ch_add_i[winner];
    assign tcdm_we_o    = ch_we_i[winner];
    assign tcdm_wdata_o = ch_wdata_i[winner];
    assign tcdm_be_o    = ch_be_i[winner];

    always_comb begin
        ch_gnt_o         = 2'b00;
        ch_gnt_o[winner] = push;
    end

    assign head         = trk_q[rd_ptr_q];
    assign pop          = tcdm_r_valid_i & ~empty;
    assign ch_r_rdata_o = tcdm_r_rdata_i;
    assign ch_r_id_o    = head.id;
    assign busy_o       = ~empty;
    assign err_o        = err_q;

    always_comb begin
        ch_r_valid_o             = 2'b00;
        ch_r_valid_o[head.owner] = pop;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= 1'b0;
            lock_q      <= 1'b0;
            locked_ch_q <= 1'b0;
        end else if (push) begin
            rr_q   <= ~winner;
            lock_q <= 1'b0;
        end else if (tcdm_req_o) begin
            lock_q      <= 1'b1;
            locked_ch_q <= winner;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CNT_W'(1);
            if (tcdm_r_valid_i && empty)
                err_q <= 1'b1;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push)
            trk_q[wr_ptr_q] <= '{owner: winner, id: ch_id_i[winner]};
    end

endmodule

// File: tb/tb_axi2mem_tcdm_rw_arb.sv
// Directed bench for the TCDM read/write arbiter: round-robin, grant locking, tracker full/wrap, error and reset.
module tb_axi2mem_tcdm_rw_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 6;
    localparam int MO = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            ch_req;
    logic [1:0][AW-1:0]    ch_add;
    logic [1:0]            ch_we;
    logic [1:0][DW-1:0]    ch_wdata;
    logic [1:0][DW/8-1:0]  ch_be;
    logic [1:0][IW-1:0]    ch_id;
    logic [1:0]            ch_gnt;
    logic [1:0]            ch_r_valid;
    logic [DW-1:0]         ch_r_rdata;
    logic [IW-1:0]         ch_r_id;
    logic                  tcdm_req;
    logic [AW-1:0]         tcdm_add;
    logic                  tcdm_we;
    logic [DW-1:0]         tcdm_wdata;
    logic [DW/8-1:0]       tcdm_be;
    logic                  tcdm_gnt;
    logic                  tcdm_r_valid;
    logic [DW-1:0]         tcdm_r_rdata;
    logic                  busy;
    logic                  err;

    int checks = 0;
    int errors = 0;

    axi2mem_tcdm_rw_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_req_i(ch_req), .ch_add_i(ch_add), .ch_we_i(ch_we), .ch_wdata_i(ch_wdata),
        .ch_be_i(ch_be), .ch_id_i(ch_id), .ch_gnt_o(ch_gnt), .ch_r_valid_o(ch_r_valid),
        .ch_r_rdata_o(ch_r_rdata), .ch_r_id_o(ch_r_id),
        .tcdm_req_o(tcdm_req), .tcdm_add_o(tcdm_add), .tcdm_we_o(tcdm_we),
        .tcdm_wdata_o(tcdm_wdata), .tcdm_be_o(tcdm_be), .tcdm_gnt_i(tcdm_gnt),
        .tcdm_r_valid_i(tcdm_r_valid), .tcdm_r_rdata_i(tcdm_r_rdata),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus just after the falling edge, then settle before checking.
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [IW-1:0] id0, input logic [IW-1:0] id1);
        @(negedge clk);
        ch_req       = req;
        tcdm_gnt     = gnt;
        tcdm_r_valid = rv;
        ch_id[0]     = id0;
        ch_id[1]     = id1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, 1'b1, 1'b0, '0, '0);
        checks++; if (ch_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", ch_gnt); end
        checks++; if (ch_r_valid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", ch_r_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (tcdm_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", tcdm_req); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_g;
        logic [1:0]    exp_v;
        logic [AW-1:0] exp_a;
        logic [IW-1:0] exp_id;
        for (int k = 0; k < 5; k++) begin
            tcdm_r_rdata = DW'(32'hD000 + k);
            drive((k < 4) ? 2'b11 : 2'b00, 1'b1, (k > 0), 6'h05, 6'h2A);
            if (k < 4) begin
                exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
                exp_a = (k % 2 == 1) ? 32'h2000 : 32'h1000;
                checks++; if (ch_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", k, ch_gnt, exp_g); end
                checks++; if (tcdm_add !== exp_a) begin errors++; $display("FAIL rr_add c%0d got %h exp %h", k, tcdm_add, exp_a); end
            end
            if (k > 0) begin
                exp_v  = ((k - 1) % 2 == 1) ? 2'b10 : 2'b01;
                exp_id = ((k - 1) % 2 == 1) ? 6'h2A : 6'h05;
                checks++; if (ch_r_valid !== exp_v) begin errors++; $display("FAIL rr_rvalid c%0d got %b exp %b", k, ch_r_valid, exp_v); end
                checks++; if (ch_r_id !== exp_id) begin errors++; $display("FAIL rr_rid c%0d got %h exp %h", k, ch_r_id, exp_id); end
                checks++; if (ch_r_rdata !== DW'(32'hD000 + k)) begin errors++; $display("FAIL rr_rdata c%0d got %h", k, ch_r_rdata); end
            end
        end
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_lock();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, (k == 3), 1'b0, 6'h11, 6'h22);
            checks++; if (tcdm_add !== 32'h1000) begin errors++; $display("FAIL lock_add c%0d got %h exp 00001000", k, tcdm_add); end
            checks++; if (ch_gnt !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_gnt c%0d got %b", k, ch_gnt); end
            checks++; if (tcdm_req !== 1'b1) begin errors++; $display("FAIL lock_req c%0d got %b exp 1", k, tcdm_req); end
        end
        drive(2'b11, 1'b1, 1'b0, 6'h11, 6'h22);
        checks++; if (ch_gnt !== 2'b10) begin errors++; $display("FAIL lock_next_gnt got %b exp 10", ch_gnt); end
        checks++; if (tcdm_we !== 1'b1) begin errors++; $display("FAIL lock_next_we got %b exp 1", tcdm_we); end
        drive(2'b00, 1'b0, 1'b1, '0, '0);
        checks++; if (ch_r_valid !== 2'b01 || ch_r_id !== 6'h11) begin errors++; $display("FAIL lock_resp0 got %b/%h exp 01/11", ch_r_valid, ch_r_id); end
        drive(2'b00, 1'b0, 1'b1, '0, '0);
        checks++; if (ch_r_valid !== 2'b10 || ch_r_id !== 6'h22) begin errors++; $display("FAIL lock_resp1 got %b/%h exp 10/22", ch_r_valid, ch_r_id); end
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            drive(2'b10, 1'b1, 1'b0, '0, IW'(k));
            checks++; if (ch_gnt !== 2'b10) begin errors++; $display("FAIL full_fill_gnt c%0d got %b exp 10", k, ch_gnt); end
        end
        // Full: the same-cycle pop must not open a slot.
        drive(2'b10, 1'b1, 1'b1, '0, 6'd4);
        checks++; if (tcdm_req !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", tcdm_req); end
        checks++; if (ch_gnt !== 2'b00) begin errors++; $display("FAIL full_gnt got %b exp 00", ch_gnt); end
        checks++; if (ch_r_valid !== 2'b10 || ch_r_id !== 6'd0) begin errors++; $display("FAIL full_pop0 got %b/%h exp 10/00", ch_r_valid, ch_r_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
        drive(2'b10, 1'b1, 1'b1, '0, 6'd4);
        checks++; if (ch_gnt !== 2'b10) begin errors++; $display("FAIL full_pushpop_gnt got %b exp 10", ch_gnt); end
        checks++; if (ch_r_valid !== 2'b10 || ch_r_id !== 6'd1) begin errors++; $display("FAIL full_pop1 got %b/%h exp 10/01", ch_r_valid, ch_r_id); end
        drive(2'b10, 1'b1, 1'b0, '0, 6'd5);
        checks++; if (ch_gnt !== 2'b10) begin errors++; $display("FAIL full_push5_gnt got %b exp 10", ch_gnt); end
        drive(2'b10, 1'b1, 1'b0, '0, 6'd6);
        checks++; if (tcdm_req !== 1'b0) begin errors++; $display("FAIL full_again_req got %b exp 0", tcdm_req); end
        for (int j = 0; j < 4; j++) begin
            drive(2'b00, 1'b0, 1'b1, '0, '0);
            checks++; if (ch_r_valid !== 2'b10 || ch_r_id !== IW'(j + 2)) begin errors++; $display("FAIL wrap_order j%0d got %b/%h exp 10/%h", j, ch_r_valid, ch_r_id, j + 2); end
        end
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_err();
        drive(2'b00, 1'b0, 1'b1, '0, '0);
        checks++; if (ch_r_valid !== 2'b00) begin errors++; $display("FAIL err_rvalid got %b exp 00", ch_r_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before_edge got %b exp 0", err); end
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
        repeat (3) drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 1'b1, 1'b0, 6'd7, '0);
        drive(2'b01, 1'b1, 1'b0, 6'd8, '0);
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err_rst got %b exp 0", err); end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err_quiet got %b exp 0", err); end
        drive(2'b00, 1'b0, 1'b1, '0, '0);
        checks++; if (ch_r_valid !== 2'b00) begin errors++; $display("FAIL mid_stray_rvalid got %b exp 00", ch_r_valid); end
        drive(2'b00, 1'b0, 1'b0, '0, '0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_stray_err got %b exp 1", err); end
    endtask

    initial begin
        rst          = 1'b1;
        ch_req       = '0;
        ch_add[0]    = 32'h1000;
        ch_add[1]    = 32'h2000;
        ch_we        = 2'b10;
        ch_wdata[0]  = 32'h0;
        ch_wdata[1]  = 32'hCAFE_F00D;
        ch_be[0]     = 4'hF;
        ch_be[1]     = 4'h3;
        ch_id        = '0;
        tcdm_gnt     = 1'b0;
        tcdm_r_valid = 1'b0;
        tcdm_r_rdata = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_full_wrap();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
